vrased_monitor_gen: RTL and testbench



---
 rtl/vrased_monitor_gen.sv | 193 +++++++++++++++++++
 tb/tb_vrased_monitor_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vrased_monitor_gen.sv
// vrased_monitor_gen: parametrised VRASED-style hardware monitor.
// Checks CPU and DMA accesses against a protected region map and enforces
// atomic execution of the trusted SMEM code. On a violation it drives a
// stretched reset that is held until the CPU reaches the reset handler.
// The cause, region and count of violations are kept for later inspection.
module vrased_monitor_gen #(
    parameter int                    N_REG         = 4,
    parameter logic [16*N_REG-1:0]   REG_BASE      = {16'h6A00, 16'h0400, 16'h0230, 16'h0000},
    parameter logic [16*N_REG-1:0]   REG_SIZE      = {16'h001F, 16'h0C00, 16'h0020, 16'h0000},
    parameter logic [N_REG-1:0]      REG_RD_OK     = 4'b0000,
    parameter logic [N_REG-1:0]      REG_WR_OK     = 4'b0000,
    parameter logic [N_REG-1:0]      REG_DMA_OK    = 4'b0000,
    parameter logic [15:0]           SMEM_BASE     = 16'hA000,
    parameter logic [15:0]           SMEM_SIZE     = 16'h4000,
    parameter logic [15:0]           LST_ADDR      = 16'hA048,
    parameter logic [15:0]           RESET_HANDLER = 16'h0000,
    parameter int                    RESET_CYCLES  = 4,
    parameter int                    CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic             data_en,
    input  logic             data_wr,
    input  logic [15:0]      data_addr,
    input  logic             dma_en,
    input  logic [15:0]      dma_addr,
    input  logic             irq,
    output logic             vrf_reset,
    output logic [2:0]       viol_cause,
    output logic [2:0]       viol_region,
    output logic [CNT_W-1:0] viol_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        KILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] KILL_LOAD = 16'(RESET_CYCLES - 1);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               vrf_reset_q, vrf_reset_d;
    logic [2:0]         viol_cause_q, viol_cause_d;
    logic [2:0]         viol_region_q, viol_region_d;
    logic [CNT_W-1:0]   viol_count_q, viol_count_d;
    logic [15:0]        prev_pc_q, prev_pc_d;
    logic               prev_in_smem_q, prev_in_smem_d;

    logic               trusted;
    logic [7:0]         rd_bad;
    logic [7:0]         wr_bad;
    logic [7:0]         dma_bad;
    logic [2:0]         cause_now;
    logic [2:0]         region_now;

    // Range check done in 17 bits so base+size never wraps around.
    function automatic logic in_range(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] size);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

    // Index of the lowest set bit; callers only use it on a non-zero mask.
    function automatic logic [2:0] lowest(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

    // Decode the trusted window and the per-region permission misses.
    always_comb begin
        trusted = in_range(pc, SMEM_BASE, SMEM_SIZE);
        rd_bad  = 8'b0;
        wr_bad  = 8'b0;
        dma_bad = 8'b0;
        for (int i = 0; i < N_REG; i++) begin
            rd_bad[i]  = in_range(data_addr, REG_BASE[16*i +: 16], REG_SIZE[16*i +: 16]) && !REG_RD_OK[i];
            wr_bad[i]  = in_range(data_addr, REG_BASE[16*i +: 16], REG_SIZE[16*i +: 16]) && !REG_WR_OK[i];
            dma_bad[i] = in_range(dma_addr,  REG_BASE[16*i +: 16], REG_SIZE[16*i +: 16]) && !REG_DMA_OK[i];
        end
    end

    // Pick the highest-priority violation present this cycle (0 = none).
    always_comb begin
        cause_now  = 3'd0;
        region_now = 3'd0;
        if (data_en && !data_wr && !trusted && (|rd_bad)) begin
            cause_now  = 3'd1;
            region_now = lowest(rd_bad);
        end else if (data_en && data_wr && !trusted && (|wr_bad)) begin
            cause_now  = 3'd2;
            region_now = lowest(wr_bad);
        end else if (dma_en && (|dma_bad)) begin
            cause_now  = 3'd3;
            region_now = lowest(dma_bad);
        end else if (dma_en && trusted) begin
            cause_now  = 3'd4;
        end else if (irq && trusted) begin
            cause_now  = 3'd5;
        end else if (!prev_in_smem_q && trusted && (pc != SMEM_BASE)) begin
            cause_now  = 3'd6;
        end else if (prev_in_smem_q && !trusted && (prev_pc_q != LST_ADDR)) begin
            cause_now  = 3'd7;
        end
    end

    // Next-state logic for the RUN/KILL/HOLD sequence and the sticky log.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        vrf_reset_d    = 1'b0;
        viol_cause_d   = viol_cause_q;
        viol_region_d  = viol_region_q;
        viol_count_d   = viol_count_q;
        prev_pc_d      = RESET_HANDLER;
        prev_in_smem_d = 1'b0;
        case (state_q)
            RUN: begin
                prev_pc_d      = pc;
                prev_in_smem_d = trusted;
                if (cause_now != 3'd0) begin
                    state_d       = KILL;
                    cnt_d         = KILL_LOAD;
                    vrf_reset_d   = 1'b1;
                    viol_cause_d  = cause_now;
                    viol_region_d = region_now;
                    if (viol_count_q != {CNT_W{1'b1}}) begin
                        viol_count_d = viol_count_q + CNT_W'(1);
                    end
                end
            end
            KILL: begin
                vrf_reset_d = 1'b1;
                if (cnt_q == 16'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                vrf_reset_d = 1'b1;
                if (pc == RESET_HANDLER) begin
                    state_d     = RUN;
                    vrf_reset_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, outputs and previous-PC tracking, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= 16'd0;
            vrf_reset_q    <= 1'b0;
            viol_cause_q   <= 3'd0;
            viol_region_q  <= 3'd0;
            viol_count_q   <= '0;
            prev_pc_q      <= RESET_HANDLER;
            prev_in_smem_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            vrf_reset_q    <= vrf_reset_d;
            viol_cause_q   <= viol_cause_d;
            viol_region_q  <= viol_region_d;
            viol_count_q   <= viol_count_d;
            prev_pc_q      <= prev_pc_d;
            prev_in_smem_q <= prev_in_smem_d;
        end
    end

    assign vrf_reset   = vrf_reset_q;
    assign viol_cause  = viol_cause_q;
    assign viol_region = viol_region_q;
    assign viol_count  = viol_count_q;

endmodule

// File: tb/tb_vrased_monitor_gen.sv
// Testbench for vrased_monitor_gen: a table of one-cycle vectors with
// hand-computed outputs, plus hand-written saturation and reset-abort runs.
module tb_vrased_monitor_gen;

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic        den;
        logic        dwr;
        logic [15:0] daddr;
        logic        men;
        logic [15:0] maddr;
        logic        irq;
        logic        evrf;
        logic [2:0]  ecause;
        logic [2:0]  ereg;
        logic [7:0]  ecnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;
    logic        vrf_reset;
    logic [2:0]  viol_cause;
    logic [2:0]  viol_region;
    logic [7:0]  viol_count;

    int   checks;
    int   errors;
    vec_t vecs[$];

    vrased_monitor_gen dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .data_en     (data_en),
        .data_wr     (data_wr),
        .data_addr   (data_addr),
        .dma_en      (dma_en),
        .dma_addr    (dma_addr),
        .irq         (irq),
        .vrf_reset   (vrf_reset),
        .viol_cause  (viol_cause),
        .viol_region (viol_region),
        .viol_count  (viol_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic rst, input logic [15:0] vpc,
                                   input logic den, input logic dwr, input logic [15:0] daddr,
                                   input logic men, input logic [15:0] maddr, input logic virq,
                                   input logic evrf, input logic [2:0] ec, input logic [2:0] er,
                                   input logic [7:0] en);
        vec_t v;
        v.rst = rst; v.pc = vpc; v.den = den; v.dwr = dwr; v.daddr = daddr;
        v.men = men; v.maddr = maddr; v.irq = virq;
        v.evrf = evrf; v.ecause = ec; v.ereg = er; v.ecnt = en;
        return v;
    endfunction

    task automatic addVec(input logic rst, input logic [15:0] vpc,
                          input logic den, input logic dwr, input logic [15:0] daddr,
                          input logic men, input logic [15:0] maddr, input logic virq,
                          input logic evrf, input logic [2:0] ec, input logic [2:0] er,
                          input logic [7:0] en);
        vecs.push_back(mkVec(rst, vpc, den, dwr, daddr, men, maddr, virq, evrf, ec, er, en));
    endtask

    // Three more KILL cycles, the move to HOLD, then pc at the handler releases.
    task automatic addRecovery(input logic [2:0] ec, input logic [2:0] er, input logic [7:0] en);
        for (int k = 0; k < 4; k++) begin
            addVec(0, 16'h0000, 0, 0, 16'h0, 0, 16'h0, 0, 1, ec, er, en);
        end
        addVec(0, 16'h0000, 0, 0, 16'h0, 0, 16'h0, 0, 0, ec, er, en);
    endtask

    // Drive one vector at the falling edge and step past the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        pc        = v.pc;
        data_en   = v.den;
        data_wr   = v.dwr;
        data_addr = v.daddr;
        dma_en    = v.men;
        dma_addr  = v.maddr;
        irq       = v.irq;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic evrf, input logic [2:0] ec,
                               input logic [2:0] er, input logic [7:0] en);
        checks++;
        if ({vrf_reset, viol_cause, viol_region, viol_count} !== {evrf, ec, er, en}) begin
            errors++;
            $display("[TB] FAIL %s: got vrf=%0d cause=%0d region=%0d count=%0d, expected vrf=%0d cause=%0d region=%0d count=%0d",
                     name, vrf_reset, viol_cause, viol_region, viol_count, evrf, ec, er, en);
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; pc = 16'h0; data_en = 1'b0; data_wr = 1'b0;
        data_addr = 16'h0; dma_en = 1'b0; dma_addr = 16'h0; irq = 1'b0;
        checks = 0; errors = 0;

        // Untrusted read of region 3, stretched reset, release at pc=0.
        addVec(1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'h4000, 1, 0, 16'h6A05, 0, 16'h0000, 0, 1, 1, 3, 1);
        for (int k = 0; k < 5; k++) addVec(0, 16'h4000, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1, 3, 1);
        addVec(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 3, 1);
        // Trusted read is allowed, legal exit, write outside all regions.
        addVec(1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'hA010, 1, 0, 16'h6A05, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'hA048, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'h4000, 1, 1, 16'h8000, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0);
        // Entry not at SMEM_BASE.
        addVec(0, 16'hA010, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 6, 0, 1);
        addRecovery(6, 0, 1);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 6, 0, 1);
        addVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 6, 0, 1);
        addVec(0, 16'hA048, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 6, 0, 1);
        addVec(0, 16'h4002, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 6, 0, 1);
        // Exit from a PC other than LST_ADDR.
        addVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 6, 0, 1);
        addVec(0, 16'hA010, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 6, 0, 1);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 7, 0, 2);
        addRecovery(7, 0, 2);
        // DMA into region 2 plus irq while trusted: cause 3 wins; later violations ignored.
        addVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 7, 0, 2);
        addVec(0, 16'hA020, 0, 0, 16'h0000, 1, 16'h0400, 1, 1, 3, 2, 3);
        addVec(0, 16'h4000, 1, 0, 16'h6A05, 0, 16'h0000, 0, 1, 3, 2, 3);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 3, 2, 3);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 3, 2, 3);
        addVec(0, 16'h4000, 1, 0, 16'h6A05, 0, 16'h0000, 0, 1, 3, 2, 3);
        addVec(0, 16'h4000, 1, 1, 16'h0230, 0, 16'h0000, 0, 1, 3, 2, 3);
        addVec(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 2, 3);
        // Untrusted write into region 1.
        addVec(0, 16'h4000, 1, 1, 16'h0230, 0, 16'h0000, 0, 1, 2, 1, 4);
        addRecovery(2, 1, 4);
        // DMA outside any region while trusted.
        addVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2, 1, 4);
        addVec(0, 16'hA000, 0, 0, 16'h0000, 1, 16'h8000, 0, 1, 4, 0, 5);
        addRecovery(4, 0, 5);
        // irq while trusted.
        addVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 4, 0, 5);
        addVec(0, 16'hA004, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 5, 0, 6);
        addRecovery(5, 0, 6);
        // Region edges: last byte of region 3 hits, one past does not.
        addVec(0, 16'h4000, 0, 0, 16'h0000, 1, 16'h6A1E, 0, 1, 3, 3, 7);
        addRecovery(3, 3, 7);
        addVec(0, 16'h4000, 0, 0, 16'h0000, 1, 16'h6A1F, 0, 0, 3, 3, 7);
        addVec(0, 16'h4000, 1, 0, 16'h0250, 0, 16'h0000, 0, 0, 3, 3, 7);
        addVec(0, 16'h4000, 1, 0, 16'h022F, 0, 16'h0000, 0, 0, 3, 3, 7);
        addVec(0, 16'h4000, 1, 0, 16'h1000, 0, 16'h0000, 0, 0, 3, 3, 7);
        addVec(0, 16'h4000, 1, 0, 16'h0FFF, 0, 16'h0000, 0, 1, 1, 2, 8);
        addRecovery(1, 2, 8);
        // CPU read outranks a simultaneous DMA violation.
        addVec(0, 16'h4000, 1, 0, 16'h0230, 1, 16'h6A05, 0, 1, 1, 1, 9);
        addRecovery(1, 1, 9);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].evrf, vecs[i].ecause, vecs[i].ereg, vecs[i].ecnt);
        end

        // Reset in the middle of KILL aborts the sequence; legal entry afterwards.
        applyStimulus(mkVec(1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("abort_reset0", 0, 0, 0, 0);
        applyStimulus(mkVec(0, 16'h4000, 1, 0, 16'h6A05, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("abort_viol", 1, 1, 3, 1);
        applyStimulus(mkVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("abort_kill", 1, 1, 3, 1);
        applyStimulus(mkVec(1, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("abort_reset", 0, 0, 0, 0);
        applyStimulus(mkVec(0, 16'hA000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("abort_entry", 0, 0, 0, 0);
        applyStimulus(mkVec(0, 16'hA010, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("abort_inside", 0, 0, 0, 0);

        // Repeated violations from pc=0: one new violation every 6 cycles.
        applyStimulus(mkVec(1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("sat_reset", 0, 0, 0, 0);
        applyStimulus(mkVec(0, 16'h0000, 1, 0, 16'h6A05, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("sat_first", 1, 1, 3, 1);
        repeat (1523) @(posedge clk);
        #1;
        checkOutput("sat_254", vrf_reset, 1, 3, 8'd254);
        repeat (76) @(posedge clk);
        #1;
        checkOutput("sat_255", vrf_reset, 1, 3, 8'hFF);
        applyStimulus(mkVec(1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("sat_clear", 0, 0, 0, 0);
        applyStimulus(mkVec(0, 16'h4000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0));
        checkOutput("sat_run", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
